regfile_wb_queue: RTL and testbench

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/rf_pkg.sv | 18 +
 rtl/regfile_wb_queue_match.sv | 42 ++++
 rtl/regfile_wb_queue.sv | 187 ++++++++++++++++++
 tb/tb_regfile_wb_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg -- shared register-file constants and helpers.
//   REG_ADDR_W : architectural register index width (x0..x31)
//   X0_IDX     : index of the hard-wired zero register
//   addr_match : true when a queued destination equals a lookup address,
//                never true for x0 lookups
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0_IDX = 5'd0;

    function automatic logic addr_match(input logic [REG_ADDR_W-1:0] entry_addr,
                                        input logic [REG_ADDR_W-1:0] lookup_addr);
        return (entry_addr == lookup_addr) && (lookup_addr != X0_IDX);
    endfunction

endpackage

// File: rtl/regfile_wb_queue_match.sv
// ---------------------------------------------------------------------------
// wb_match -- youngest-match search over the writeback queue.
// Walks the slots from the oldest (rd pointer) towards the youngest; the last
// matching valid slot wins, so hit_data is the most recent pending value.
// Only used when the bypass feature (WB_QUEUE_BYPASS_EN) is built in.
// Ports:
//   valid    : per-slot valid bits
//   addr     : per-slot destination register
//   data     : per-slot write data
//   oldest   : slot index of the oldest entry
//   q_addr   : lookup register index
//   hit_data : data of the youngest matching entry, 0 when none
// ---------------------------------------------------------------------------
module wb_match
    import rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]                 valid,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr,
    input  logic [DEPTH-1:0][XLEN-1:0]       data,
    input  logic [$clog2(DEPTH)-1:0]         oldest,
    input  logic [REG_ADDR_W-1:0]            q_addr,
    output logic [XLEN-1:0]                  hit_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx_s;

    // Age-ordered scan: later (younger) matches overwrite earlier ones.
    always_comb begin
        hit_data = '0;
        idx_s    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s    = oldest + PTR_W'(k);
            hit_data = (valid[idx_s] && addr_match(addr[idx_s], q_addr)) ? data[idx_s] : hit_data;
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// regfile_wb_queue -- small FIFO of pending register-file writebacks.
// Requests are accepted on a valid/ready handshake, x0 writes are consumed
// and dropped, and the oldest entry is presented on the register-file write
// port until the port is free (rf_stall low). Pending destinations can be
// looked up on two read ports (busy1/2), optionally with data bypass.
//
// Optional feature macro: WB_QUEUE_BYPASS_EN
//   defined   : fwd_validN = busyN, fwd_dataN = youngest matching entry data
//   undefined : fwd_valid1/2 and fwd_data1/2 tied to 0
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : writeback request handshake
//   in_addr/in_data       : destination register / value
//   flush                 : drop every queued entry at the next edge
//   rf_stall              : register-file write port busy this cycle
//   rf_we/rf_addr/rf_data : register-file write port (oldest entry)
//   q_addr1/2, busy1/2    : pending-write lookup
//   fwd_valid1/2, fwd_data1/2 : bypass data
//   count                 : current occupancy
// ---------------------------------------------------------------------------
module regfile_wb_queue
    import rf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [REG_ADDR_W-1:0]        in_addr,
    input  logic [XLEN-1:0]              in_data,
    input  logic                         flush,
    input  logic                         rf_stall,
    output logic                         rf_we,
    output logic [REG_ADDR_W-1:0]        rf_addr,
    output logic [XLEN-1:0]              rf_data,
    input  logic [REG_ADDR_W-1:0]        q_addr1,
    input  logic [REG_ADDR_W-1:0]        q_addr2,
    output logic                         busy1,
    output logic                         busy2,
    output logic                         fwd_valid1,
    output logic                         fwd_valid2,
    output logic [XLEN-1:0]              fwd_data1,
    output logic [XLEN-1:0]              fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]                 valid_r;
    logic [DEPTH-1:0]                 valid_nxt_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_r;
    logic [DEPTH-1:0][XLEN-1:0]       data_r;
    logic [PTR_W-1:0]                 wr_ptr_r;
    logic [PTR_W-1:0]                 rd_ptr_r;
    logic [CNT_W-1:0]                 count_r;
    logic [CNT_W-1:0]                 count_nxt_s;
    logic                             accept_s;
    logic                             push_s;
    logic                             pop_s;
    logic                             busy1_s;
    logic                             busy2_s;

    // in_ready depends only on occupancy and flush, never on rf_stall.
    assign in_ready = (count_r < CNT_W'(DEPTH)) && !flush;
    assign accept_s = in_valid && in_ready;
    // x0 writes complete the handshake but never occupy a slot.
    assign push_s   = accept_s && (in_addr != X0_IDX);
    assign rf_we    = (count_r != {CNT_W{1'b0}});
    assign pop_s    = rf_we && !rf_stall;
    assign count    = count_r;

    // Oldest entry on the write port; forced to 0 when the queue is empty.
    always_comb begin
        rf_addr = '0;
        rf_data = '0;
        if (rf_we) begin
            rf_addr = addr_r[rd_ptr_r];
            rf_data = data_r[rd_ptr_r];
        end else begin
            rf_addr = '0;
            rf_data = '0;
        end
    end

    // Next valid vector and occupancy for a normal (non-flush) edge.
    always_comb begin
        valid_nxt_s = valid_r;
        count_nxt_s = count_r;
        if (pop_s) begin
            valid_nxt_s[rd_ptr_r] = 1'b0;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
        // Push never targets the popped slot: a full queue blocks pushes.
        if (push_s) begin
            valid_nxt_s[wr_ptr_r] = 1'b1;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: pointers, valid bits, occupancy; flush beats push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            valid_r  <= valid_nxt_s;
            count_r  <= count_nxt_s;
            wr_ptr_r <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        end
    end

    // Payload storage; push_s is already blocked during flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            data_r <= '0;
        end else if (push_s) begin
            addr_r[wr_ptr_r] <= in_addr;
            data_r[wr_ptr_r] <= in_data;
        end else begin
            addr_r <= addr_r;
            data_r <= data_r;
        end
    end

    // Pending-write lookup: plain OR over all valid slots, no priority.
    always_comb begin
        busy1_s = 1'b0;
        busy2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy1_s = busy1_s | (valid_r[i] & addr_match(addr_r[i], q_addr1));
            busy2_s = busy2_s | (valid_r[i] & addr_match(addr_r[i], q_addr2));
        end
    end

    assign busy1 = busy1_s;
    assign busy2 = busy2_s;

`ifdef WB_QUEUE_BYPASS_EN
    wb_match #(.XLEN(XLEN), .DEPTH(DEPTH)) u_match1 (
        .valid    (valid_r),
        .addr     (addr_r),
        .data     (data_r),
        .oldest   (rd_ptr_r),
        .q_addr   (q_addr1),
        .hit_data (fwd_data1)
    );

    wb_match #(.XLEN(XLEN), .DEPTH(DEPTH)) u_match2 (
        .valid    (valid_r),
        .addr     (addr_r),
        .data     (data_r),
        .oldest   (rd_ptr_r),
        .q_addr   (q_addr2),
        .hit_data (fwd_data2)
    );

    assign fwd_valid1 = busy1_s;
    assign fwd_valid2 = busy2_s;
`else
    assign fwd_valid1 = 1'b0;
    assign fwd_valid2 = 1'b0;
    assign fwd_data1  = {XLEN{1'b0}};
    assign fwd_data2  = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_queue -- self-checking bench for regfile_wb_queue.
// A queue of {addr,data} entries is the reference: every cycle the outputs
// are compared against it, then it is updated with the same accept / pop /
// flush rules the block must follow. Directed sequences first, then random.
// ---------------------------------------------------------------------------
module tb_regfile_wb_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_addr;
    logic [XLEN-1:0]   in_data;
    logic              flush;
    logic              rf_stall;
    logic              rf_we;
    logic [4:0]        rf_addr;
    logic [XLEN-1:0]   rf_data;
    logic [4:0]        q_addr1;
    logic [4:0]        q_addr2;
    logic              busy1;
    logic              busy2;
    logic              fwd_valid1;
    logic              fwd_valid2;
    logic [XLEN-1:0]   fwd_data1;
    logic [XLEN-1:0]   fwd_data2;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t mq[$];

    regfile_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .flush      (flush),
        .rf_stall   (rf_stall),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .q_addr1    (q_addr1),
        .q_addr2    (q_addr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .fwd_valid1 (fwd_valid1),
        .fwd_valid2 (fwd_valid2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every output against the reference queue contents.
    task automatic check_outs();
        logic [XLEN-1:0] f1;
        logic [XLEN-1:0] f2;
        logic            b1;
        logic            b2;
        logic [4:0]      ea;
        logic [XLEN-1:0] ed;
        f1 = '0; f2 = '0; b1 = 1'b0; b2 = 1'b0; ea = '0; ed = '0;
        foreach (mq[i]) begin
            if (q_addr1 != 5'd0 && mq[i].a == q_addr1) begin b1 = 1'b1; f1 = mq[i].d; end
            if (q_addr2 != 5'd0 && mq[i].a == q_addr2) begin b2 = 1'b1; f2 = mq[i].d; end
        end
        if (mq.size() > 0) begin ea = mq[0].a; ed = mq[0].d; end
        chk("count",    count,    mq.size());
        chk("rf_we",    rf_we,    mq.size() > 0);
        chk("rf_addr",  rf_addr,  ea);
        chk("rf_data",  rf_data,  ed);
        chk("in_ready", in_ready, (mq.size() < DEPTH) && !flush);
        chk("busy1",    busy1,    b1);
        chk("busy2",    busy2,    b2);
`ifdef WB_QUEUE_BYPASS_EN
        chk("fwd_valid1", fwd_valid1, b1);
        chk("fwd_valid2", fwd_valid2, b2);
        chk("fwd_data1",  fwd_data1,  f1);
        chk("fwd_data2",  fwd_data2,  f2);
`else
        chk("fwd_valid1", fwd_valid1, 1'b0);
        chk("fwd_valid2", fwd_valid2, 1'b0);
        chk("fwd_data1",  fwd_data1,  32'd0);
        chk("fwd_data2",  fwd_data2,  32'd0);
`endif
    endtask

    // One clock cycle: drive after the falling edge, check, then advance model.
    task automatic step(input bit v, input logic [4:0] a, input logic [XLEN-1:0] d,
                        input bit st, input bit fl, input logic [4:0] q1, input logic [4:0] q2);
        bit acc;
        @(negedge clk);
        in_valid = v; in_addr = a; in_data = d;
        rf_stall = st; flush = fl; q_addr1 = q1; q_addr2 = q2;
        #1;
        check_outs();
        acc = v && (mq.size() < DEPTH) && !fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && !st) void'(mq.pop_front());
            if (acc && a != 5'd0) mq.push_back('{a: a, d: d});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        flush = 1'b0; rf_stall = 1'b0; q_addr1 = '0; q_addr2 = '0;
        #1;
        check_outs();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single write goes straight through.
        step(1'b1, 5'd1, 32'd69, 1'b0, 1'b0, 5'd1, 5'd0);
        step(1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 5'd1, 5'd0);
        idle(1);

        // x0 writes are consumed but dropped.
        step(1'b1, 5'd0, 32'd5, 1'b0, 1'b0, 5'd0, 5'd0);
        idle(2);

        // Fill under stall, then drain in order.
        step(1'b1, 5'd2, 32'h102, 1'b1, 1'b0, 5'd2, 5'd5);
        step(1'b1, 5'd3, 32'h103, 1'b1, 1'b0, 5'd3, 5'd2);
        step(1'b1, 5'd4, 32'h104, 1'b1, 1'b0, 5'd4, 5'd5);
        step(1'b1, 5'd5, 32'h105, 1'b1, 1'b0, 5'd5, 5'd4);
        step(1'b1, 5'd6, 32'h106, 1'b1, 1'b0, 5'd6, 5'd2);
        // Full with pop: push blocked, count drops by one.
        step(1'b1, 5'd6, 32'h106, 1'b0, 1'b0, 5'd6, 5'd3);
        // Simultaneous push and pop keeps count.
        step(1'b1, 5'd7, 32'h107, 1'b0, 1'b0, 5'd7, 5'd4);
        idle(5);

        // Two writes to one register: youngest wins for bypass.
        step(1'b1, 5'd7, 32'h11, 1'b1, 1'b0, 5'd7, 5'd0);
        step(1'b1, 5'd7, 32'h22, 1'b1, 1'b0, 5'd7, 5'd0);
        step(1'b1, 5'd9, 32'h33, 1'b1, 1'b0, 5'd7, 5'd0);
        // Flush with three entries and a concurrent push.
        step(1'b1, 5'd8, 32'h44, 1'b0, 1'b1, 5'd7, 5'd8);
        idle(2);

        // Asynchronous reset between edges with two entries queued.
        step(1'b1, 5'd10, 32'h55, 1'b1, 1'b0, 5'd10, 5'd11);
        step(1'b1, 5'd11, 32'h66, 1'b1, 1'b0, 5'd10, 5'd11);
        @(negedge clk);
        in_valid = 1'b0; rf_stall = 1'b1;
        #2 rst_n = 1'b0;
        mq.delete();
        #1;
        check_outs();
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(3);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
